// File: rtl/uriscv_irq_ctrl.sv
// uriscv_irq_ctrl: fixed-priority platform interrupt controller with claim/complete register bus.
// Ports: clk, rst (sync, active-high); irq_src_i[NUM_SRC] peripheral lines (bit n = ID n+1);
//   req_i/we_i/addr_i (word index = byte address [5:2])/wdata_i -> rdata_o/ack_o one cycle later;
//   irq_o registered "any eligible source" to the core.
// Registers: 0 PENDING (RO), 1 ENABLE, 2 EDGE, 3 CLAIM (read claims, write completes), 4 INSV (RO).
// Define URISCV_IRQ_SYNC_EN to pass irq_src_i through a 2-flop synchronizer before the gateways.
module uriscv_irq_ctrl #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src_i,
    input  logic               req_i,
    input  logic               we_i,
    input  logic [3:0]         addr_i,
    input  logic [31:0]        wdata_i,
    output logic [31:0]        rdata_o,
    output logic               ack_o,
    output logic               irq_o
);
    logic [NUM_SRC-1:0] src, prev, pending, enable, edge_en, insv;
    logic [NUM_SRC-1:0] elig, gw_set, win_oh, comp_oh;
    logic [4:0]         win_id;
    logic [31:0]        rd;
    logic               claim, complete, unused_wdata;

`ifdef URISCV_IRQ_SYNC_EN
    logic [NUM_SRC-1:0] sync1, sync2;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_src_i;
            sync2 <= sync1;
        end
    end
    assign src = sync2;
`else
    assign src = irq_src_i;
`endif

    assign unused_wdata = ^wdata_i;
    assign claim        = req_i && !we_i && addr_i == 4'd3;
    assign complete     = req_i && we_i && addr_i == 4'd3;
    assign elig         = pending & enable & ~insv;
    // Edge sources latch a rise even while in service; level sources re-arm only once completed.
    assign gw_set       = (edge_en & src & ~prev) | (~edge_en & src & ~insv);

    // Descending scan so the lowest eligible index is the last (winning) assignment.
    always_comb begin
        win_id  = '0;
        win_oh  = '0;
        comp_oh = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i]) begin
                win_id    = 5'(i + 1);
                win_oh    = '0;
                win_oh[i] = 1'b1;
            end
            comp_oh[i] = insv[i] && wdata_i[4:0] == 5'(i + 1);
        end
    end

    assign rd = addr_i == 4'd0 ? 32'(pending) :
                addr_i == 4'd1 ? 32'(enable)  :
                addr_i == 4'd2 ? 32'(edge_en) :
                addr_i == 4'd3 ? 32'(win_id)  :
                addr_i == 4'd4 ? 32'(insv)    : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_o   <= 1'b0;
            rdata_o <= '0;
            irq_o   <= 1'b0;
            prev    <= '0;
            pending <= '0;
            enable  <= '0;
            edge_en <= '0;
            insv    <= '0;
        end else begin
            ack_o   <= req_i;
            rdata_o <= req_i && !we_i ? rd : '0;
            irq_o   <= |elig;
            prev    <= src;
            // Gateway set is OR'ed after the claim clear so a same-cycle set wins.
            pending <= (pending & ~({NUM_SRC{claim}} & win_oh)) | gw_set;
            insv    <= (insv | ({NUM_SRC{claim}} & win_oh)) & ~({NUM_SRC{complete}} & comp_oh);
            if (req_i && we_i && addr_i == 4'd1) enable <= wdata_i[NUM_SRC-1:0];
            if (req_i && we_i && addr_i == 4'd2) edge_en <= wdata_i[NUM_SRC-1:0];
        end
    end
endmodule
